// File: rtl/hazard_destination_tracker.sv
// Carries destination register, write-enable and load flags from ID through EX/MEM/WB
// for the hazard/forwarding unit, injects bubbles into EX, and counts stall cycles.
module hazard_destination_tracker #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_destination,
  input  logic                      id_rf_enable,
  input  logic                      id_load_instruction,
  input  logic                      nop_signal,
  input  logic                      flush,
  input  logic                      stats_clear,
  output logic [REG_ADDR_WIDTH-1:0] ex_destination,
  output logic [REG_ADDR_WIDTH-1:0] mem_destination,
  output logic [REG_ADDR_WIDTH-1:0] wb_destination,
  output logic                      ex_rf_enable,
  output logic                      mem_rf_enable,
  output logic                      wb_rf_enable,
  output logic                      ex_load_instruction,
  output logic                      mem_load_instruction,
  output logic [COUNT_WIDTH-1:0]    stall_count
);

  logic id_rf_clean;
  logic id_load_clean;
  logic bubble;

  // A write to $zero must never forward or stall, so it is reduced to the bubble encoding.
  always_comb begin
    id_rf_clean   = id_rf_enable & (id_destination != '0);
    id_load_clean = id_load_instruction & id_rf_clean;
    bubble        = nop_signal | flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_destination       <= '0;
      ex_rf_enable         <= 1'b0;
      ex_load_instruction  <= 1'b0;
      mem_destination      <= '0;
      mem_rf_enable        <= 1'b0;
      mem_load_instruction <= 1'b0;
      wb_destination       <= '0;
      wb_rf_enable         <= 1'b0;
    end else begin
      if (bubble) begin
        ex_destination      <= '0;
        ex_rf_enable        <= 1'b0;
        ex_load_instruction <= 1'b0;
      end else begin
        ex_destination      <= id_destination;
        ex_rf_enable        <= id_rf_clean;
        ex_load_instruction <= id_load_clean;
      end
      mem_destination      <= ex_destination;
      mem_rf_enable        <= ex_rf_enable;
      mem_load_instruction <= ex_load_instruction;
      wb_destination       <= mem_destination;
      wb_rf_enable         <= mem_rf_enable;
    end
  end

  // Clear has priority over a same-edge increment; the count saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stats_clear) begin
      stall_count <= '0;
    end else if (nop_signal && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_destination_tracker.sv
// Directed, table-driven bench for hazard_destination_tracker; a second instance with a
// 2-bit counter exercises saturation.
module tb_hazard_destination_tracker;

  logic       clk;
  logic       reset_n;
  logic [4:0] id_destination;
  logic       id_rf_enable;
  logic       id_load_instruction;
  logic       nop_signal;
  logic       flush;
  logic       stats_clear;

  logic [4:0]  ex_destination, mem_destination, wb_destination;
  logic        ex_rf_enable, mem_rf_enable, wb_rf_enable;
  logic        ex_load_instruction, mem_load_instruction;
  logic [15:0] stall_count;

  logic [4:0] s_ex_destination, s_mem_destination, s_wb_destination;
  logic       s_ex_rf_enable, s_mem_rf_enable, s_wb_rf_enable;
  logic       s_ex_load_instruction, s_mem_load_instruction;
  logic [1:0] s_stall_count;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [4:0]  dest;
    logic        rf;
    logic        ld;
    logic        nop;
    logic        fl;
    logic        clr;
    logic [4:0]  ex_d;
    logic        ex_rf;
    logic        ex_ld;
    logic [4:0]  mem_d;
    logic        mem_rf;
    logic        mem_ld;
    logic [4:0]  wb_d;
    logic        wb_rf;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
  } vec_t;

  vec_t vecs [14];

  hazard_destination_tracker #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_destination(id_destination), .id_rf_enable(id_rf_enable),
    .id_load_instruction(id_load_instruction), .nop_signal(nop_signal),
    .flush(flush), .stats_clear(stats_clear),
    .ex_destination(ex_destination), .mem_destination(mem_destination),
    .wb_destination(wb_destination), .ex_rf_enable(ex_rf_enable),
    .mem_rf_enable(mem_rf_enable), .wb_rf_enable(wb_rf_enable),
    .ex_load_instruction(ex_load_instruction),
    .mem_load_instruction(mem_load_instruction), .stall_count(stall_count)
  );

  hazard_destination_tracker #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(2)) dut_small (
    .clk(clk), .reset_n(reset_n),
    .id_destination(id_destination), .id_rf_enable(id_rf_enable),
    .id_load_instruction(id_load_instruction), .nop_signal(nop_signal),
    .flush(flush), .stats_clear(stats_clear),
    .ex_destination(s_ex_destination), .mem_destination(s_mem_destination),
    .wb_destination(s_wb_destination), .ex_rf_enable(s_ex_rf_enable),
    .mem_rf_enable(s_mem_rf_enable), .wb_rf_enable(s_wb_rf_enable),
    .ex_load_instruction(s_ex_load_instruction),
    .mem_load_instruction(s_mem_load_instruction), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] dest, input logic rf, input logic ld,
                               input logic nop, input logic fl, input logic clr);
    id_destination      = dest;
    id_rf_enable        = rf;
    id_load_instruction = ld;
    nop_signal          = nop;
    flush               = fl;
    stats_clear         = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkPipe(input string tag, input logic [4:0] exd, input logic exrf,
                           input logic exld, input logic [4:0] md, input logic mrf,
                           input logic mld, input logic [4:0] wd, input logic wrf);
    checkOutput({tag, " ex_destination"}, 32'(ex_destination), 32'(exd));
    checkOutput({tag, " ex_rf_enable"}, 32'(ex_rf_enable), 32'(exrf));
    checkOutput({tag, " ex_load_instruction"}, 32'(ex_load_instruction), 32'(exld));
    checkOutput({tag, " mem_destination"}, 32'(mem_destination), 32'(md));
    checkOutput({tag, " mem_rf_enable"}, 32'(mem_rf_enable), 32'(mrf));
    checkOutput({tag, " mem_load_instruction"}, 32'(mem_load_instruction), 32'(mld));
    checkOutput({tag, " wb_destination"}, 32'(wb_destination), 32'(wd));
    checkOutput({tag, " wb_rf_enable"}, 32'(wb_rf_enable), 32'(wrf));
    checkOutput({tag, " small ex_destination"}, 32'(s_ex_destination), 32'(exd));
    checkOutput({tag, " small wb_destination"}, 32'(s_wb_destination), 32'(wd));
  endtask

  task automatic checkCounts(input string tag, input logic [15:0] cnt, input logic [1:0] cnt_s);
    checkOutput({tag, " stall_count"}, 32'(stall_count), 32'(cnt));
    checkOutput({tag, " small stall_count"}, 32'(s_stall_count), 32'(cnt_s));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //         dest  rf    ld    nop   fl    clr   ex_d  exrf  exld  mem_d mrf   mld   wb_d  wbrf  cnt     cnt_s
    vecs[0]  = '{5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 16'd0, 2'd0};
    vecs[1]  = '{5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 16'd0, 2'd0};
    vecs[2]  = '{5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 16'd0, 2'd0};
    vecs[3]  = '{5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd6, 1'b1, 16'd1, 2'd1};
    vecs[4]  = '{5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 16'd1, 2'd1};
    vecs[5]  = '{5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 16'd1, 2'd1};
    vecs[6]  = '{5'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 16'd1, 2'd1};
    vecs[7]  = '{5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 16'd1, 2'd1};
    vecs[8]  = '{5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b1, 5'd10, 1'b0, 16'd2, 2'd2};
    vecs[9]  = '{5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 16'd3, 2'd3};
    vecs[10] = '{5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 16'd3, 2'd3};
    vecs[11] = '{5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 16'd3, 2'd3};
    vecs[12] = '{5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 16'd0, 2'd0};
    vecs[13] = '{5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1, 5'd12, 1'b1, 16'd0, 2'd0};

    reset_n             = 1'b0;
    id_destination      = 5'd0;
    id_rf_enable        = 1'b0;
    id_load_instruction = 1'b0;
    nop_signal          = 1'b0;
    flush               = 1'b0;
    stats_clear         = 1'b0;

    // Hold ID with junk during reset; outputs must stay zero across an edge.
    #2;
    id_destination = 5'd17; id_rf_enable = 1'b1; id_load_instruction = 1'b1; nop_signal = 1'b1;
    #10;
    checkPipe("reset", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkCounts("reset", 16'd0, 2'd0);

    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].dest, vecs[i].rf, vecs[i].ld, vecs[i].nop, vecs[i].fl, vecs[i].clr);
      checkPipe($sformatf("vec%0d", i), vecs[i].ex_d, vecs[i].ex_rf, vecs[i].ex_ld,
                vecs[i].mem_d, vecs[i].mem_rf, vecs[i].mem_ld, vecs[i].wb_d, vecs[i].wb_rf);
      checkCounts($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].cnt_s);
    end

    // Five stalls: the wide counter climbs, the 2-bit one pins at 3.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkCounts($sformatf("sat%0d", i), 16'(i), (i >= 3) ? 2'd3 : 2'(i));
      checkOutput($sformatf("sat%0d ex_destination", i), 32'(ex_destination), 32'd0);
    end
    applyStimulus(5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkCounts("clear_with_nop", 16'd0, 2'd0);
    applyStimulus(5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCounts("after_clear", 16'd1, 2'd1);

    applyStimulus(5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkPipe("full", 5'd5, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 5'd3, 1'b1);

    // Asynchronous reset between edges must clear everything without a clock.
    #2;
    reset_n = 1'b0;
    #1;
    checkPipe("async_reset", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkCounts("async_reset", 16'd0, 2'd0);
    id_destination = 5'd8; id_rf_enable = 1'b1; id_load_instruction = 1'b1;
    @(posedge clk);
    #3;
    checkPipe("reset_held", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    reset_n = 1'b1;
    applyStimulus(5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkPipe("post_reset", 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkPipe("post_reset2", 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
